counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Run-control sequencer for the 4-bit LED counter datapath. From the 50 MHz board clock it generates a count-enable tick and steps a WIDTH-bit count up or down between 0 and a programmable limit. It supports start, hold, clear and completion signalling. The count drives the board LEDs directly, active-low. It replaces free-running divided-clock counting: every register is clocked by CLOCK_50, and no derived clocks are used.

## Interface
- DIV, 50_000_000: CLOCK_50 cycles per count step; must be ≥ 2 (benches use 4).
- WIDTH, 4: count / LIMIT / LED width.
- CLOCK_50  in  1  single system clock; all state updates on its rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  synchronous one-cycle pulse; latches UP and LIMIT and (re)starts a run.
- HOLD  in  1  level; while high in RUN, counting and prescaler freeze.
- CLEAR  in  1  synchronous one-cycle pulse; abort to IDLE.
- UP  in  1  direction, sampled on START: 1 counts 0→LIMIT, 0 counts LIMIT→0.
- LIMIT  in  WIDTH  terminal magnitude, unsigned, sampled on START.
- COUNT  out  WIDTH  current count.
- LED  out  WIDTH  ~COUNT (LEDs lit at logic 0).
- BUSY  out  1  high in RUN and HOLD.
- DONE  out  1  completion flag (see Configuration).

## Operation
- States are IDLE, RUN, HOLD and DONE.
- Reset values: state IDLE, COUNT=0, LED=all ones, BUSY=0, DONE=0, prescaler=0, latched dir=up, latched limit=0.
- Run values:
  - start value = UP ? 0 : LIMIT.
  - terminal value = UP ? LIMIT : 0.
- Per-cycle priority: CLEAR > START > HOLD > tick.
- CLEAR (any state): go to IDLE, COUNT=0, prescaler=0, DONE=0.
- START (any state, no CLEAR): latch UP/LIMIT, COUNT=start value, prescaler=0, go to RUN. START during RUN, HOLD or DONE restarts the run.
- RUN:
  - If HOLD=1, go to HOLD; the prescaler holds its value.
  - Otherwise the prescaler increments and wraps at DIV-1. The wrap cycle is the tick.
  - On a tick with COUNT≠terminal: COUNT ±1 per the latched direction.
  - On a tick with COUNT==terminal: go to DONE; COUNT stays at the terminal value.
- HOLD: COUNT and prescaler are frozen. HOLD=0 returns to RUN and the prescaler resumes from its frozen value.
- DONE: COUNT holds. Exit only by START or CLEAR.
- LIMIT=0: a run shows 0 for one tick period, then enters DONE.
- The count never wraps modulo 2^WIDTH in normal mode. A terminal value equal to all ones is legal.
- LIMIT/UP changes while not at START have no effect on a run in progress.

## Timing
- START accepted at edge N: COUNT=start value and BUSY=1 after edge N.
- First step at edge N+DIV. Each value is displayed for exactly DIV cycles of RUN.
- DONE is asserted LIMIT+1 tick periods after START, i.e. after edge N+(LIMIT+1)·DIV, plus any cycles spent in HOLD.
- HOLD and CLEAR take effect on the edge where they are sampled; outputs are registered.
- RST_N low forces all reset values immediately, independent of CLOCK_50. Deassertion is used synchronously (two-flop synchronizer on release).

## Configuration
- COUNTER_CTRL_AUTORELOAD_EN undefined:
  - Tick at terminal enters DONE.
  - DONE is a level, high while in DONE; BUSY falls on the same edge.
- COUNTER_CTRL_AUTORELOAD_EN defined:
  - Tick at terminal reloads the start value and stays in RUN.
  - DONE pulses high for exactly one cycle at each reload; BUSY stays high.
  - The DONE state is unreachable.

## Structure
- Package counter_ctrl_pkg holds:
  - the state enum typedef (IDLE, RUN, HOLD, DONE);
  - DIV_DEFAULT = 50_000_000 and WIDTH_DEFAULT = 4.
- Sub-module tick_gen: prescaler parameterised by DIV, with inputs clr and en and a one-cycle tick output. Width is $clog2(DIV).
- counter_ctrl contains the FSM, the direction/limit latches and the count register.

## Test plan
All scenarios use DIV=4, WIDTH=4.
- Up count: START with UP=1, LIMIT=3 → COUNT 0,1,2,3, each held 4 cycles; DONE=1 and BUSY=0 16 cycles after START; LED=4'b1100 at the end.
- Down count: START with UP=0, LIMIT=5 → COUNT 5,4,3,2,1,0, each held 4 cycles; DONE asserted after 24 cycles; COUNT stays 0.
- Hold: HOLD high 10 cycles during COUNT=2 → COUNT frozen, prescaler resumes from its frozen value, DONE delayed by exactly 10 cycles.
- Collisions:
  - CLEAR and START in the same cycle during RUN → IDLE, COUNT=0, BUSY=0.
  - START during DONE → restarts at the start value.
- Reset: RST_N low mid-run at COUNT=7 → COUNT=0, LED=4'b1111, BUSY=0 and DONE=0 without waiting for a clock edge.
- Autoreload (COUNTER_CTRL_AUTORELOAD_EN defined): UP=1, LIMIT=15 → 15 followed by 0, DONE high exactly one cycle per wrap, BUSY constantly 1.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and defaults for the LED counter run-control sequencer.
//   state_t       : sequencer states (IDLE, RUN, HOLD, DONE)
//   DIV_DEFAULT   : board clock cycles per count step (50 MHz -> 1 Hz)
//   WIDTH_DEFAULT : count / limit / LED width
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DIV_DEFAULT   = 50_000_000;
    localparam int WIDTH_DEFAULT = 4;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_tick.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle count-enable tick every DIV enabled cycles.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (already release-synchronised)
//   clr   : synchronous clear of the prescaler (highest priority)
//   en    : advance the prescaler this cycle; when low the value is frozen
//   tick  : high in the enabled cycle in which the prescaler wraps at DIV-1
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // The wrap cycle itself is the tick, so the step lands on the wrap edge.
    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_gen

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Run-control sequencer for the LED counter: steps COUNT up or down between 0
// and a latched LIMIT once every DIV cycles of CLOCK_50, with start, hold,
// clear and completion signalling. All state is on CLOCK_50.
//   CLOCK_50 : system clock          RST_N : async active-low reset
//   START    : 1-cycle (re)start     HOLD  : level, freezes a run
//   CLEAR    : 1-cycle abort to IDLE UP    : direction, sampled on START
//   LIMIT    : terminal magnitude, sampled on START
//   COUNT    : current count         LED   : ~COUNT (active-low LEDs)
//   BUSY     : high in RUN / HOLD    DONE  : completion flag
// Build option COUNTER_CTRL_AUTORELOAD_EN: when defined, reaching the terminal
// value reloads the start value, stays in RUN and pulses DONE for one cycle;
// when undefined, the run stops in DONE with DONE held high.
// -----------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic             START,
    input  logic             HOLD,
    input  logic             CLEAR,
    input  logic             UP,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] COUNT,
    output logic [WIDTH-1:0] LED,
    output logic             BUSY,
    output logic             DONE
);
    // Reset asserts immediately; release passes through two flops so every
    // register leaves reset on the same clock edge.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_int_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             up_q, up_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             active;
    logic             tick;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] reload_val;

    // HOLD state with HOLD released behaves like RUN in that same cycle, so
    // the prescaler loses no cycles beyond those actually held.
    assign active = ((state_q == ST_RUN) || (state_q == ST_HOLD)) &&
                    !HOLD && !START && !CLEAR;

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (CLOCK_50),
        .rst_n (rst_int_n),
        .clr   (CLEAR | START),
        .en    (active),
        .tick  (tick)
    );

    assign terminal   = up_q ? limit_q : '0;
    assign reload_val = up_q ? '0 : limit_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        up_d    = up_q;
        done_d  = 1'b0;

        if (CLEAR) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (START) begin
            up_d    = UP;
            limit_d = LIMIT;
            count_d = UP ? '0 : LIMIT;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_HOLD: begin
                    if (HOLD) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        if (tick) begin
                            if (count_q == terminal) begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                                count_d = reload_val;
                                done_d  = 1'b1;
`else
                                state_d = ST_DONE;
`endif
                            end else if (up_q) begin
                                count_d = count_q + WIDTH'(1);
                            end else begin
                                count_d = count_q - WIDTH'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

`ifndef COUNTER_CTRL_AUTORELOAD_EN
        done_d = (state_d == ST_DONE);
`endif
        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    end

`ifndef COUNTER_CTRL_AUTORELOAD_EN
    // Only the autoreload build needs the reload value.
    logic unused_reload;
    assign unused_reload = ^reload_val;
`endif

    always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '0;
            up_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            up_q    <= up_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign COUNT = count_q;
    assign LED   = ~count_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
// Self-checking bench for counter_ctrl with DIV=4, WIDTH=4. Expected
// {BUSY, DONE, COUNT, LED} vectors come from a cycle model of the run and are
// queued when a run is started, then popped and compared once per cycle.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;
    localparam int DIV   = 4;
    localparam int WIDTH = 4;
    localparam int EW    = 2 * WIDTH + 2;

    logic             CLOCK_50 = 1'b0;
    logic             RST_N    = 1'b0;
    logic             START    = 1'b0;
    logic             HOLD     = 1'b0;
    logic             CLEAR    = 1'b0;
    logic             UP       = 1'b1;
    logic [WIDTH-1:0] LIMIT    = '0;
    logic [WIDTH-1:0] COUNT;
    logic [WIDTH-1:0] LED;
    logic             BUSY;
    logic             DONE;

    logic [EW-1:0] exp_q[$];
    int            n_compared   = 0;
    int            n_mismatched = 0;
    int            hold_start   = 0;
    int            hold_len     = 0;

    counter_ctrl #(
        .DIV   (DIV),
        .WIDTH (WIDTH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .START    (START),
        .HOLD     (HOLD),
        .CLEAR    (CLEAR),
        .UP       (UP),
        .LIMIT    (LIMIT),
        .COUNT    (COUNT),
        .LED      (LED),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    // ---------------- clock / reset ----------------
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic in_hold(input int e);
        return (e >= hold_start) && (e < hold_start + hold_len);
    endfunction

    // ---------------- model: expected vectors for one run ----------------
    // j = cycles after the START edge; p = prescaler progress (hold edges excluded).
    task automatic push_run(input logic up, input int lim, input int p_end);
        int               period;
        int               j;
        int               p;
        int               p_prev;
        int               k;
        logic [WIDTH-1:0] c;
        logic             b;
        logic             d;
        period = (lim + 1) * DIV;
        j      = 0;
        p      = 0;
        p_prev = -1;
        forever begin
            if (j > 0 && !in_hold(j)) p++;
            if (p > p_end) break;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
            k = p % period;
            c = up ? WIDTH'(k / DIV) : WIDTH'(lim - k / DIV);
            b = 1'b1;
            d = (p > 0) && (k == 0) && (p != p_prev);
`else
            k = (p < period) ? p : period - 1;
            c = up ? WIDTH'(k / DIV) : WIDTH'(lim - k / DIV);
            b = (p < period);
            d = !b;
`endif
            exp_q.push_back({b, d, c, ~c});
            p_prev = p;
            j++;
        end
    endtask

    task automatic do_start(input logic up, input int lim);
        UP    = up;
        LIMIT = WIDTH'(lim);
        START = 1'b1;
        step();
        START = 1'b0;
        // Inputs changing mid-run must not disturb the latched run.
        UP    = 1'($urandom_range(0, 1));
        LIMIT = WIDTH'($urandom_range(0, 15));
    endtask

    task automatic drain(input string name);
        logic [EW-1:0] e;
        logic [EW-1:0] o;
        int            j;
        j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {BUSY, DONE, COUNT, LED};
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("FAIL %s cyc %0d: got busy/done/count/led=%b, expected %b", name, j, o, e);
            end
            if (exp_q.size() > 0) begin
                HOLD = in_hold(j + 1);
                step();
                j++;
            end
        end
        HOLD     = 1'b0;
        hold_len = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [EW-1:0] o;
        RST_N = 1'b0;
        repeat (3) step();
        o = {BUSY, DONE, COUNT, LED};
        n_compared++;
        if (o !== {2'b00, 4'h0, 4'hf}) begin
            n_mismatched++;
            $display("FAIL reset_state: got %b, expected %b", o, {2'b00, 4'h0, 4'hf});
        end
        RST_N = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_up_count();
        push_run(1'b1, 3, 16 + 3);
        do_start(1'b1, 3);
        drain("up_count");
`ifndef COUNTER_CTRL_AUTORELOAD_EN
        n_compared++;
        if (LED !== 4'b1100 || DONE !== 1'b1 || BUSY !== 1'b0) begin
            n_mismatched++;
            $display("FAIL up_end: got led=%b done=%b busy=%b, expected 1100 1 0", LED, DONE, BUSY);
        end
`endif
    endtask

    task automatic test_start_during_done();
        push_run(1'b0, 2, 12 + 2);
        do_start(1'b0, 2);
        drain("restart_done");
    endtask

    task automatic test_down_count();
        push_run(1'b0, 5, 24 + 4);
        do_start(1'b0, 5);
        drain("down_count");
    endtask

    task automatic test_limit_zero();
        push_run(1'b1, 0, 4 + 2);
        do_start(1'b1, 0);
        drain("limit_zero");
    endtask

    task automatic test_all_ones();
        push_run(1'b1, 15, 64 + 6);
        do_start(1'b1, 15);
        drain("all_ones");
    endtask

    task automatic test_hold();
        hold_start = 10;
        hold_len   = 10;
        push_run(1'b1, 3, 16 + 3);
        do_start(1'b1, 3);
        drain("hold");
    endtask

    task automatic test_collision();
        logic [EW-1:0] o;
        do_start(1'b1, 9);
        repeat (5) step();
        START = 1'b1;
        CLEAR = 1'b1;
        step();
        START = 1'b0;
        CLEAR = 1'b0;
        for (int i = 0; i < 2; i++) begin
            o = {BUSY, DONE, COUNT, LED};
            n_compared++;
            if (o !== {2'b00, 4'h0, 4'hf}) begin
                n_mismatched++;
                $display("FAIL clear_start_%0d: got %b, expected %b", i, o, {2'b00, 4'h0, 4'hf});
            end
            repeat (6) step();
        end
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] o;
        do_start(1'b1, 9);
        repeat (29) step();
        n_compared++;
        if (COUNT !== 4'd7) begin
            n_mismatched++;
            $display("FAIL pre_reset_count: got %0d, expected 7", COUNT);
        end
        #3;
        RST_N = 1'b0;
        #1;
        o = {BUSY, DONE, COUNT, LED};
        n_compared++;
        if (o !== {2'b00, 4'h0, 4'hf}) begin
            n_mismatched++;
            $display("FAIL async_reset: got %b, expected %b", o, {2'b00, 4'h0, 4'hf});
        end
        step();
        RST_N = 1'b1;
        repeat (4) step();
        o = {BUSY, DONE, COUNT, LED};
        n_compared++;
        if (o !== {2'b00, 4'h0, 4'hf}) begin
            n_mismatched++;
            $display("FAIL post_reset_idle: got %b, expected %b", o, {2'b00, 4'h0, 4'hf});
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_up_count();
        test_start_during_done();
        test_down_count();
        test_limit_zero();
        test_all_ones();
        test_hold();
        test_collision();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_counter_ctrl
